pad_cfg_ctrl: RTL and testbench

- Lives in chip_core and sits directly upstream of the bidir pad ring.
- Owns the per-pad control bits: OE enable, CS, SL, IE, PU, PD.
- Bits are programmed over a 3-wire serial interface driven from ordinary input pads (sclk, sdi, csn), which are asynchronous and oversampled in the core clock domain.
- User-logic output data and OE pass through to the pads, gated by the programmed configuration.

---
 rtl/pad_cfg_if.sv | 19 +
 rtl/pad_cfg_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_pad_cfg_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pad_cfg_if.sv
// Serial configuration bus for pad_cfg_ctrl: the three asynchronous pad-level
// signals (serial clock, serial data, frame select) carried as one bundle.
interface pad_cfg_if;
  logic cfg_sclk_i;
  logic cfg_sdi_i;
  logic cfg_csn_i;

  modport master (
    output cfg_sclk_i,
    output cfg_sdi_i,
    output cfg_csn_i
  );

  modport slave (
    input cfg_sclk_i,
    input cfg_sdi_i,
    input cfg_csn_i
  );
endinterface

// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: per-pad control registers for the bidir pad ring, programmed
// through an oversampled 3-wire serial interface (16-bit frames, MSB first).
// Frame: {cmd[1:0], idx[5:0], rsvd[1:0], cfg[5:0]}, cfg = {oe_en,cs,sl,ie,pu,pd}.
// Optional feature macro PAD_CFG_READBACK_EN adds cfg_sdo_o, which streams
// {cfg_err, 0, last_idx, 00, cfg[last_idx]} during the next frame.
module pad_cfg_ctrl #(
  parameter int NUM_BIDIR   = 42,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pad_cfg_if.slave             cfg,
  input  logic [NUM_BIDIR-1:0] core_out,
  input  logic [NUM_BIDIR-1:0] core_oe,
  output logic [NUM_BIDIR-1:0] bidir_out,
  output logic [NUM_BIDIR-1:0] bidir_oe,
  output logic [NUM_BIDIR-1:0] bidir_cs,
  output logic [NUM_BIDIR-1:0] bidir_sl,
  output logic [NUM_BIDIR-1:0] bidir_ie,
  output logic [NUM_BIDIR-1:0] bidir_pu,
  output logic [NUM_BIDIR-1:0] bidir_pd,
  output logic                 cfg_busy,
  output logic                 cfg_err
`ifdef PAD_CFG_READBACK_EN
  ,
  output logic                 cfg_sdo_o
`endif
);

  localparam logic [6:0] NUM_W7 = 7'(NUM_BIDIR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, csn_sync;
  logic                   sclk_s, sdi_s, csn_s;
  logic                   sclk_prev;
  logic                   sclk_rise;

  logic [15:0]            shreg;
  logic [4:0]             bit_cnt;
  logic [15:0]            shreg_init;

  logic [NUM_BIDIR-1:0]   oe_en;

  logic [1:0]             cmd;
  logic [5:0]             idx;
  logic [5:0]             cfg_f;
  logic                   idx_ok;
  logic                   commit_valid;

  // Synchronizers: csn idles high so reset does not look like a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      csn_sync  <= '1;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], cfg.cfg_sclk_i};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], cfg.cfg_sdi_i};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], cfg.cfg_csn_i};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;

  // Frame field decode and commit validity
  always_comb begin
    cmd          = shreg[15:14];
    idx          = shreg[13:8];
    cfg_f        = shreg[5:0];
    idx_ok       = ({1'b0, idx} < NUM_W7);
    commit_valid = (bit_cnt == 5'd16) && !((cmd == 2'b01) && !idx_ok);
  end

`ifdef PAD_CFG_READBACK_EN
  logic [5:0] last_idx;
  logic [5:0] last_cfg;

  // Readback image of the last written pad, loaded at frame start
  always_comb begin
    last_cfg = '0;
    for (int i = 0; i < NUM_BIDIR; i++) begin
      if (6'(i) == last_idx) begin
        last_cfg = {oe_en[i], bidir_cs[i], bidir_sl[i], bidir_ie[i], bidir_pu[i], bidir_pd[i]};
      end
    end
    shreg_init = {cfg_err, 1'b0, last_idx, 2'b00, last_cfg};
  end

  assign cfg_sdo_o = (state != ST_IDLE) & shreg[15];
`else
  assign shreg_init = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: csn low opens a frame, csn high closes it into one commit cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (!csn_s) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (csn_s) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  assign cfg_busy = (state != ST_IDLE);

  // Shift register and saturating bit counter; a rise seen with csn high is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!csn_s) begin
            shreg   <= shreg_init;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (!csn_s && sclk_rise) begin
            shreg <= {shreg[14:0], sdi_s};
            if (bit_cnt != 5'd17) bit_cnt <= bit_cnt + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pad configuration registers and error flag, updated only in COMMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oe_en    <= '0;
      bidir_cs <= '0;
      bidir_sl <= '0;
      bidir_ie <= '1;
      bidir_pu <= '0;
      bidir_pd <= '0;
      cfg_err  <= 1'b0;
    end else if (state == ST_COMMIT) begin
      cfg_err <= ~commit_valid;
      if (commit_valid) begin
        case (cmd)
          2'b01: begin
            for (int i = 0; i < NUM_BIDIR; i++) begin
              if (6'(i) == idx) begin
                oe_en[i]    <= cfg_f[5];
                bidir_cs[i] <= cfg_f[4];
                bidir_sl[i] <= cfg_f[3];
                bidir_ie[i] <= cfg_f[2];
                bidir_pu[i] <= cfg_f[1];
                bidir_pd[i] <= cfg_f[0];
              end
            end
          end
          2'b10: begin
            oe_en    <= {NUM_BIDIR{cfg_f[5]}};
            bidir_cs <= {NUM_BIDIR{cfg_f[4]}};
            bidir_sl <= {NUM_BIDIR{cfg_f[3]}};
            bidir_ie <= {NUM_BIDIR{cfg_f[2]}};
            bidir_pu <= {NUM_BIDIR{cfg_f[1]}};
            bidir_pd <= {NUM_BIDIR{cfg_f[0]}};
          end
          2'b11: begin
            oe_en    <= '0;
            bidir_cs <= '0;
            bidir_sl <= '0;
            bidir_ie <= '1;
            bidir_pu <= '0;
            bidir_pd <= '0;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PAD_CFG_READBACK_EN
  // Most recent pad index written by a single-pad write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx <= '0;
    end else if ((state == ST_COMMIT) && commit_valid && (cmd == 2'b01)) begin
      last_idx <= idx;
    end
  end
`endif

  assign bidir_out = core_out;
  assign bidir_oe  = core_oe & oe_en;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Self-checking bench for pad_cfg_ctrl: directed frames from the test plan
// followed by randomized frames, all compared against a frame-level model.
module tb_pad_cfg_ctrl;
  localparam int NUM  = 42;
  localparam int SYNC = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NUM-1:0] core_out, core_oe;
  logic [NUM-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd;
  logic           cfg_busy, cfg_err;
`ifdef PAD_CFG_READBACK_EN
  logic           cfg_sdo_o;
`endif

  pad_cfg_if cfg_bus ();

  pad_cfg_ctrl #(.NUM_BIDIR(NUM), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_bus),
    .core_out  (core_out),
    .core_oe   (core_oe),
    .bidir_out (bidir_out),
    .bidir_oe  (bidir_oe),
    .bidir_cs  (bidir_cs),
    .bidir_sl  (bidir_sl),
    .bidir_ie  (bidir_ie),
    .bidir_pu  (bidir_pu),
    .bidir_pd  (bidir_pd),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err)
`ifdef PAD_CFG_READBACK_EN
    ,
    .cfg_sdo_o (cfg_sdo_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model: per-pad cfg {oe_en,cs,sl,ie,pu,pd}, error flag, last written idx
  logic [5:0] m_cfg [NUM];
  logic       m_err;
  logic [5:0] m_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) m_cfg[i] = 6'b000100;
    m_err  = 1'b0;
    m_last = 6'd0;
  endtask

  task automatic model_commit(input logic [31:0] f, input int nbits);
    int cmd, idx;
    logic [5:0] c;
    if (nbits != 16) begin
      m_err = 1'b1;
      return;
    end
    cmd = int'((f >> 14) & 32'd3);
    idx = int'((f >> 8) & 32'd63);
    c   = f[5:0];
    if (cmd == 1 && idx >= NUM) begin
      m_err = 1'b1;
      return;
    end
    m_err = 1'b0;
    case (cmd)
      1: begin m_cfg[idx] = c; m_last = 6'(idx); end
      2: for (int i = 0; i < NUM; i++) m_cfg[i] = c;
      3: for (int i = 0; i < NUM; i++) m_cfg[i] = 6'b000100;
      default: ;
    endcase
  endtask

  function automatic logic [NUM-1:0] model_vec(input int b);
    logic [NUM-1:0] v;
    for (int i = 0; i < NUM; i++) v[i] = m_cfg[i][b];
    return v;
  endfunction

  task automatic check_pads(input string tag);
    logic [NUM-1:0] oe_exp;
    core_out = NUM'({$urandom, $urandom});
    core_oe  = NUM'({$urandom, $urandom});
    #1;
    oe_exp = core_oe & model_vec(5);
    check({tag, ".out"}, 64'(bidir_out), 64'(core_out));
    check({tag, ".oe"},  64'(bidir_oe),  64'(oe_exp));
    check({tag, ".cs"},  64'(bidir_cs),  64'(model_vec(4)));
    check({tag, ".sl"},  64'(bidir_sl),  64'(model_vec(3)));
    check({tag, ".ie"},  64'(bidir_ie),  64'(model_vec(2)));
    check({tag, ".pu"},  64'(bidir_pu),  64'(model_vec(1)));
    check({tag, ".pd"},  64'(bidir_pd),  64'(model_vec(0)));
    check({tag, ".busy"}, 64'(cfg_busy), 64'(0));
    check({tag, ".err"},  64'(cfg_err),  64'(m_err));
`ifdef PAD_CFG_READBACK_EN
    if (rst_n) check({tag, ".sdo_idle"}, 64'(cfg_sdo_o), 64'(0));
`endif
  endtask

  // Send nbits of f MSB first; abort_bit >= 0 pulls reset after that many pulses
  task automatic send_frame(input string tag, input logic [31:0] f, input int nbits,
                            input int abort_bit);
    int lat;
    logic [15:0] rb_exp, rb_got;
    rb_exp = {m_err, 1'b0, m_last, 2'b00, m_cfg[m_last]};
    rb_got = '0;
    @(negedge clk);
    cfg_bus.cfg_csn_i = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = nbits - 1; k >= 0; k--) begin
      if (nbits - 1 - k == abort_bit) begin
        rst_n = 1'b0;
        model_reset();
        check_pads({tag, ".rst"});
        cfg_bus.cfg_csn_i  = 1'b1;
        cfg_bus.cfg_sclk_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_pads({tag, ".after_rst"});
        return;
      end
      cfg_bus.cfg_sdi_i = f[k];
      repeat (3) @(negedge clk);
`ifdef PAD_CFG_READBACK_EN
      rb_got = {rb_got[14:0], cfg_sdo_o};
`endif
      cfg_bus.cfg_sclk_i = 1'b1;
      repeat (3) @(negedge clk);
      cfg_bus.cfg_sclk_i = 1'b0;
    end
    repeat (3) @(negedge clk);
    cfg_bus.cfg_csn_i = 1'b1;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (!cfg_busy) begin
        lat = n;
        break;
      end
    end
    check({tag, ".latency_in_window"}, 64'(lat >= SYNC + 1 && lat <= SYNC + 3), 64'(1));
    model_commit(f, nbits);
    check_pads(tag);
`ifdef PAD_CFG_READBACK_EN
    if (nbits == 16) check({tag, ".readback"}, 64'(rb_got), 64'(rb_exp));
`endif
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [31:0] f;
    int nb, r;
    rst_n = 1'b0;
    cfg_bus.cfg_csn_i  = 1'b1;
    cfg_bus.cfg_sclk_i = 1'b0;
    cfg_bus.cfg_sdi_i  = 1'b0;
    core_out = '0;
    core_oe  = '1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check_pads("reset");
    core_oe = '1;
    #1;
    check("reset.oe_all_ones", 64'(bidir_oe), 64'(0));

    send_frame("wr_pad3",    32'h433F, 16, -1);
    send_frame("bcast_ie",   32'h8004, 16, -1);
    send_frame("restore",    32'hC000, 16, -1);
    send_frame("wr_idx50",   32'h723F, 16, -1);
    send_frame("noop_clr",   32'h0000, 16, -1);
    send_frame("wr_pad7",    32'h0748 | 32'h4000, 16, -1);
    send_frame("short15",    32'h0000_4215, 15, -1);
    send_frame("long17",     32'h0001_4215, 17, -1);
    send_frame("wr_pad5",    32'h452A, 16, -1);
    send_frame("noop_rb",    32'h0000, 16, -1);
    send_frame("abort_bit8", 32'h433F, 16, 8);
    send_frame("post_abort", 32'h4A21, 16, -1);

    for (int t = 0; t < 40; t++) begin
      f  = 32'($urandom);
      r  = int'($urandom_range(0, 9));
      nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      send_frame($sformatf("rnd%0d", t), f, nb, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
